// File: rtl/inst_fetch_unit.sv
// Sequential instruction fetch with a small response FIFO that pre-classifies each word for the immediate decoder.
// Optional build macro ILLEGAL_INST_EN adds the registered illegal_inst flag per buffered entry.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [2:0]  InstFormat,
    output logic        sign_ext
`ifdef ILLEGAL_INST_EN
    ,
    output logic        illegal_inst
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_SB = 3'd3,
        FMT_U  = 3'd4,
        FMT_UJ = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [2:0] fmt;
        logic       sext;
    } cls_t;

    // Unknown opcodes fall back to R with no sign extension.
    function automatic cls_t classify(input logic [31:0] w);
        cls_t c;
        c.fmt  = FMT_R;
        c.sext = 1'b1;
        case (w[6:0])
            7'b0110011:                         c.sext = 1'b0;
            7'b0010011, 7'b0000011, 7'b1100111: c.fmt  = FMT_I;
            7'b1110011: begin
                c.fmt  = FMT_I;
                c.sext = 1'b0;
            end
            7'b0100011:                         c.fmt  = FMT_S;
            7'b1100011:                         c.fmt  = FMT_SB;
            7'b0110111, 7'b0010111:             c.fmt  = FMT_U;
            7'b1101111:                         c.fmt  = FMT_UJ;
            default:                            c.sext = 1'b0;
        endcase
        return c;
    endfunction

`ifdef ILLEGAL_INST_EN
    function automatic logic is_illegal(input logic [31:0] w);
        logic ill;
        case (w[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111: ill = 1'b0;
            default: ill = 1'b1;
        endcase
        if (w[1:0] != 2'b11) ill = 1'b1;
        return ill;
    endfunction
`endif

    logic          r_started;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic [31:0]   r_mem_inst [FIFO_DEPTH];
    logic [31:0]   r_mem_pc   [FIFO_DEPTH];
    logic [2:0]    r_mem_fmt  [FIFO_DEPTH];
    logic          r_mem_sext [FIFO_DEPTH];
`ifdef ILLEGAL_INST_EN
    logic          r_mem_ill  [FIFO_DEPTH];
`endif

    logic          w_empty;
    logic          w_pop;
    logic          w_accept;
    logic          w_resp;
    logic          w_push;
    logic [CW:0]   w_level;
    logic [31:0]   w_redir_pc;
    cls_t          w_cls;

    assign w_empty    = (r_count == '0);
    assign inst_valid = !w_empty && !redirect;
    assign w_pop      = inst_valid && inst_ready;

    // Requests in flight plus buffered words never exceed the FIFO, so a push always has room.
    assign w_level  = {1'b0, r_outstanding} + {1'b0, r_count} - (CW + 1)'(w_pop);
    assign imem_req = r_started && !redirect && (w_level < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr = r_fetch_pc;
    assign w_accept = imem_req && imem_ready;

    assign w_resp     = imem_rvalid && (r_outstanding != '0);
    assign w_push     = w_resp && (r_drop_cnt == '0) && !redirect;
    assign w_redir_pc = {redirect_pc[31:2], 2'b00};
    assign w_cls      = classify(imem_rdata);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_started     <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_started <= 1'b1;
            if (redirect) begin
                // Everything still in flight is stale; a response landing now is already dropped.
                r_fetch_pc    <= w_redir_pc;
                r_resp_pc     <= w_redir_pc;
                r_outstanding <= r_outstanding - CW'(w_resp);
                r_drop_cnt    <= r_outstanding - CW'(w_resp);
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
                r_count       <= '0;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
                r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_resp);
                if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + PW'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
            r_mem_fmt[r_wr_ptr]  <= w_cls.fmt;
            r_mem_sext[r_wr_ptr] <= w_cls.sext;
`ifdef ILLEGAL_INST_EN
            r_mem_ill[r_wr_ptr]  <= is_illegal(imem_rdata);
`endif
        end
    end

    // Head fields read as zero while the buffer is empty, which also covers the reset state.
    always_comb begin
        inst       = '0;
        inst_pc    = '0;
        InstFormat = '0;
        sign_ext   = 1'b0;
        if (!w_empty) begin
            inst       = r_mem_inst[r_rd_ptr];
            inst_pc    = r_mem_pc[r_rd_ptr];
            InstFormat = r_mem_fmt[r_rd_ptr];
            sign_ext   = r_mem_sext[r_rd_ptr];
        end
    end

`ifdef ILLEGAL_INST_EN
    assign illegal_inst = w_empty ? 1'b0 : r_mem_ill[r_rd_ptr];
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a latency-configurable memory model feeds the DUT and
// every consumed head is compared against the entry queued when its fetch was accepted.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  InstFormat;
    logic        sign_ext;
`ifdef ILLEGAL_INST_EN
    logic        illegal_inst;
`endif

    inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .InstFormat(InstFormat),
        .sign_ext(sign_ext)
`ifdef ILLEGAL_INST_EN
        ,
        .illegal_inst(illegal_inst)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word, expected format, expected sign_ext.
    logic [31:0] TBL_W [8] = '{32'hFFF00093, 32'h00112023, 32'h00000063, 32'h000012B7,
                               32'h0000006F, 32'h00000033, 32'h30529073, 32'h0000007F};
    logic [2:0]  TBL_F [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd0};
    logic        TBL_S [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    typedef struct {
        logic [31:0] pc;
        int          idx;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          mode = 0;
    int          n_acc = 0;
    logic [31:0] exp_fetch = RESET_PC;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return (mode != 0) ? int'(a[4:2]) : 0;
    endfunction

    // Memory model and scoreboard: observe the handshake mid-cycle, drive responses after the edge.
    initial begin
        exp_t  e;
        pend_t p;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                pend_q.delete();
                exp_fetch = RESET_PC;
                n_acc = 0;
            end else if (redirect) begin
                check_eq("redir_no_req", 32'(imem_req), 32'd0);
                check_eq("redir_no_valid", 32'(inst_valid), 32'd0);
                exp_q.delete();
                exp_fetch = {redirect_pc[31:2], 2'b00};
            end else begin
                if (inst_valid && inst_ready) begin
                    check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("sb_inst", inst, TBL_W[e.idx]);
                        check_eq("sb_pc", inst_pc, e.pc);
                        check_eq("sb_fmt", 32'(InstFormat), 32'(TBL_F[e.idx]));
                        check_eq("sb_sext", 32'(sign_ext), 32'(TBL_S[e.idx]));
`ifdef ILLEGAL_INST_EN
                        check_eq("sb_illegal", 32'(illegal_inst), 32'(e.idx == 7));
`endif
                    end
                end
                if (imem_req && imem_ready) begin
                    check_eq("fetch_addr", imem_addr, exp_fetch);
                    e.pc  = imem_addr;
                    e.idx = idx_of(imem_addr);
                    exp_q.push_back(e);
                    p.addr = imem_addr;
                    p.due  = cyc + lat;
                    pend_q.push_back(p);
                    exp_fetch = exp_fetch + 32'd4;
                    n_acc++;
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = TBL_W[idx_of(p.addr)];
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Returns in the first cycle with rst_n high.
    task automatic do_reset(input int l, input int m, input logic rdy, input logic irdy);
        step();
        rst_n    = 1'b0;
        redirect = 1'b0;
        lat      = l;
        mode     = m;
        step();
        imem_ready = rdy;
        inst_ready = irdy;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bit seen;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b1;
        inst_ready  = 1'b0;

        // Reset state
        run(2);
        @(negedge clk);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", imem_addr, RESET_PC);
        check_eq("rst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_pc", inst_pc, 32'd0);
        check_eq("rst_fmt", 32'(InstFormat), 32'd0);
        check_eq("rst_sext", 32'(sign_ext), 32'd0);

        // Streaming with 1-cycle memory
        step();
        rst_n = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        check_eq("t1_req_first_cycle", 32'(imem_req), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            check_eq("t1_req", 32'(imem_req), 32'd1);
            check_eq("t1_addr", imem_addr, 32'(4 * i));
            if (i >= 2) begin
                check_eq("t1_valid", 32'(inst_valid), 32'd1);
                check_eq("t1_pc", inst_pc, 32'(4 * (i - 2)));
            end
        end

        // Back-pressure fills the buffer, then drains in order
        do_reset(1, 0, 1'b1, 1'b0);
        run(12);
        @(negedge clk);
        check_eq("t2_accepts", 32'(n_acc), 32'd4);
        check_eq("t2_req_stall", 32'(imem_req), 32'd0);
        check_eq("t2_valid", 32'(inst_valid), 32'd1);
        step();
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t2_drain_pc", inst_pc, 32'(4 * i));
            step();
        end

        // Redirect with two stale fetches in flight
        do_reset(3, 1, 1'b0, 1'b1);
        step();
        imem_ready = 1'b1;
        step();
        step();
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect   = 1'b0;
        imem_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_req", 32'(imem_req), 32'd1);
        check_eq("t3_addr", imem_addr, 32'h0000_0100);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (inst_valid) begin
                seen = 1'b1;
                check_eq("t3_first_pc", inst_pc, 32'h0000_0100);
                check_eq("t3_first_inst", inst, TBL_W[0]);
            end else begin
                step();
                @(negedge clk);
            end
        end
        check_eq("t3_head_seen", 32'(seen), 32'd1);
        run(10);

        // Format table coverage through the scoreboard
        do_reset(1, 1, 1'b1, 1'b1);
        run(24);

        // Reset while the buffer is full
        inst_ready = 1'b0;
        run(10);
        @(negedge clk);
        check_eq("t5_full_valid", 32'(inst_valid), 32'd1);
        check_eq("t5_full_req", 32'(imem_req), 32'd0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_valid", 32'(inst_valid), 32'd0);
        check_eq("t5_req", 32'(imem_req), 32'd0);
        check_eq("t5_addr", imem_addr, RESET_PC);
        step();
        @(negedge clk);
        check_eq("t5_req_resume", 32'(imem_req), 32'd1);
        check_eq("t5_addr_resume", imem_addr, RESET_PC);

        // Back-to-back redirects while responses are arriving; the last one wins
        do_reset(2, 1, 1'b1, 1'b1);
        run(7);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        step();
        redirect_pc = 32'h0000_0083;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check_eq("t6_addr", imem_addr, 32'h0000_0080);
        run(20);
        inst_ready = 1'b0;
        run(3);
        check_eq("t6_accepts", 32'(n_acc > 8), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
